// File: rtl/backscatter_modulator.sv
// backscatter_modulator
// Sequences one backscatter packet (GUARD symbols, then NUM_BITS data symbols),
// generates a square-wave frequency-shift carrier and applies phase codewords:
// data bit 0 keeps the carrier phase, data bit 1 inverts it. It also drives the
// payload source's trigger/sending strobes so both blocks share symbol boundaries.
//
// Build option: define BACKSCATTER_GUARD_TONE_EN to radiate the bare carrier
// during GUARD (lets the receiver lock). Without it rf_switch stays 0 during
// GUARD, but the carrier still runs so data-phase timing is identical.

module backscatter_modulator #(
    parameter int SYMBOL_CYCLES = 50,
    parameter int HALF_PERIOD   = 5,
    parameter int GUARD_SYMBOLS = 4,
    parameter int NUM_BITS      = 144,
    parameter int SAMPLE_OFFSET = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        data_in,
    output logic        src_trigger,
    output logic        src_sending,
    output logic        rf_switch,
    output logic        symbol_strobe,
    output logic [15:0] bit_count,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] SYM_LAST   = 16'(SYMBOL_CYCLES - 1);
    localparam logic [15:0] HALF_LAST  = 16'(HALF_PERIOD - 1);
    localparam logic [15:0] GUARD_LAST = 16'(GUARD_SYMBOLS - 1);
    localparam logic [15:0] LAST_BIT   = 16'(NUM_BITS);
    localparam logic [15:0] SAMPLE_AT  = 16'(SAMPLE_OFFSET);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GUARD    = 2'd1,
        ST_MODULATE = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] sym_cnt;
    logic [15:0] half_cnt;
    logic [15:0] guard_cnt;
    logic        cur_bit;
    logic        carrier;
    logic        rf_next;
    logic        sym_wrap;
    logic        half_wrap;
    logic        active;
    logic        next_active;

    assign sym_wrap    = (sym_cnt == SYM_LAST);
    assign half_wrap   = (half_cnt == HALF_LAST);
    assign active      = (state == ST_GUARD) || (state == ST_MODULATE);
    assign next_active = (next_state == ST_GUARD) || (next_state == ST_MODULATE);

    // Next-state decode, Moore strobes and the value rf_switch takes next cycle
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        next_state    = state;
        src_trigger   = 1'b0;
        src_sending   = 1'b0;
        busy          = 1'b0;
        symbol_strobe = 1'b0;
        rf_next       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (enable) next_state = ST_GUARD;
            end
            ST_GUARD: begin
                src_trigger = 1'b1;
                busy        = 1'b1;
                if (!enable)
                    next_state = ST_IDLE;
                else if (sym_wrap && (guard_cnt == GUARD_LAST))
                    next_state = ST_MODULATE;
            end
            ST_MODULATE: begin
                src_trigger   = 1'b1;
                src_sending   = 1'b1;
                busy          = 1'b1;
                symbol_strobe = (sym_cnt == 16'd0);
                if (!enable)
                    next_state = ST_IDLE;
                else if (sym_wrap && (bit_count == LAST_BIT))
                    next_state = ST_DONE;
            end
            ST_DONE: begin
                // Holds here while enable stays high so a packet never retriggers.
                if (!enable) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase

        // rf_switch is registered, so it is chosen by the state being entered;
        // that forces it low on the very edge that aborts or completes.
        case (next_state)
            ST_MODULATE: rf_next = carrier ^ cur_bit;
            ST_GUARD: begin
`ifdef BACKSCATTER_GUARD_TONE_EN
                rf_next = carrier;
`else
                rf_next = 1'b0;
`endif
            end
            default: rf_next = 1'b0;
        endcase
    end

    // State register, registered RF drive and the one-cycle completion pulse
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            state     <= ST_IDLE;
            rf_switch <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= next_state;
            rf_switch <= rf_next;
            done      <= (state == ST_MODULATE) && (next_state == ST_DONE);
        end
    end

    // Symbol, guard and carrier counters plus the sampled data bit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sym_cnt   <= 16'd0;
            half_cnt  <= 16'd0;
            guard_cnt <= 16'd0;
            bit_count <= 16'd0;
            cur_bit   <= 1'b0;
            carrier   <= 1'b0;
        end else if (active && next_active) begin
            // Carrier free-runs across symbol and GUARD->MODULATE boundaries.
            if (half_wrap) begin
                half_cnt <= 16'd0;
                carrier  <= ~carrier;
            end else begin
                half_cnt <= half_cnt + 16'd1;
            end

            sym_cnt <= sym_wrap ? 16'd0 : sym_cnt + 16'd1;

            if (state == ST_GUARD && sym_wrap)
                guard_cnt <= guard_cnt + 16'd1;

            if (state == ST_MODULATE) begin
                if (sym_cnt == 16'd0)
                    bit_count <= bit_count + 16'd1;
                if (sym_cnt == SAMPLE_AT)
                    cur_bit <= data_in;
            end
        end else begin
            // Not running: carrier and counters sit at zero so the next packet
            // starts with carrier=0 and a fresh half-period.
            sym_cnt   <= 16'd0;
            half_cnt  <= 16'd0;
            guard_cnt <= 16'd0;
            carrier   <= 1'b0;
            // Packet start or abort clears the data-side state; a normal
            // completion keeps bit_count visible until the next packet.
            if ((state == ST_IDLE && next_state == ST_GUARD) ||
                (active && next_state == ST_IDLE)) begin
                bit_count <= 16'd0;
                cur_bit   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/backscatter_modulator.md
Name: backscatter_modulator

Overview:
- Downstream of the bit-serial payload source; sequences one packet and converts the source's serial bit into the RF-switch drive.
- Generates a square-wave frequency-shift carrier and applies codeword translation: bit 0 leaves the carrier phase unchanged, bit 1 inverts it (180°).
- Drives the source's trigger/sending strobes so the symbol boundaries of both blocks stay aligned.

Parameters:
- SYMBOL_CYCLES, 50: clock cycles per data symbol; must equal the source's per-bit period.
- HALF_PERIOD, 5: clock cycles per carrier half-period; the carrier toggles every HALF_PERIOD cycles.
- GUARD_SYMBOLS, 4: unmodulated symbols between packet start and the first data bit.
- NUM_BITS, 144: data symbols per packet.
- SAMPLE_OFFSET, 1: symbol-counter value at which data_in is sampled.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low
- enable  in  1  packet window from the excitation detector, level-sensitive
- data_in  in  1  serial payload bit from the source
- src_trigger  out  1  source trigger; high in GUARD and MODULATE
- src_sending  out  1  source shift enable; high in MODULATE only
- rf_switch  out  1  antenna switch drive
- symbol_strobe  out  1  one-cycle pulse at sym_cnt==0 in MODULATE
- bit_count  out  16  data symbols started in the current packet
- busy  out  1  high in GUARD and MODULATE
- done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset values: all outputs 0. FSM state = IDLE. sym_cnt, half_cnt, guard_cnt, bit_count, cur_bit and carrier all 0.
- IDLE -> GUARD when enable=1.
  - On that transition clear sym_cnt, half_cnt, guard_cnt and bit_count; set carrier=0.
- GUARD:
  - sym_cnt counts 0..SYMBOL_CYCLES-1 and wraps.
  - guard_cnt increments on each wrap.
  - When guard_cnt reaches GUARD_SYMBOLS-1 and sym_cnt wraps -> MODULATE, with sym_cnt=0.
- MODULATE:
  - sym_cnt counts 0..SYMBOL_CYCLES-1.
  - At sym_cnt==0: bit_count increments and symbol_strobe pulses.
  - At sym_cnt==SAMPLE_OFFSET: cur_bit <= data_in.
  - When sym_cnt wraps and bit_count==NUM_BITS -> DONE.
- DONE:
  - done=1 for exactly one cycle on entry.
  - Hold in DONE, with all strobes and rf_switch at 0, until enable=0; then -> IDLE. A packet never retriggers while enable stays high.
- Carrier:
  - half_cnt counts 0..HALF_PERIOD-1 in GUARD and MODULATE.
  - carrier toggles on wrap.
  - Phase is continuous across the symbol and state boundaries.
- rf_switch is registered:
  - MODULATE: carrier ^ cur_bit.
  - GUARD: see Optional Feature.
  - IDLE/DONE: 0.
- Bit timing: the source updates its bit on its first trigger cycle of each symbol; SAMPLE_OFFSET=1 samples it one cycle later.
  - The new phase appears on rf_switch at sym_cnt==SAMPLE_OFFSET+2. This is fixed latency; a bench checks it exactly.
  - Before the first sample, cur_bit=0 for the first symbol.
- Abort: enable=0 in GUARD or MODULATE -> IDLE on the next edge.
  - All outputs go 0 that edge and done is not pulsed.
  - src_trigger low re-initialises the source.
- Widths: counters are 16-bit. Parameters must satisfy SYMBOL_CYCLES > SAMPLE_OFFSET+2 and HALF_PERIOD ≥ 1.
- Asynchronous reset mid-packet: immediate return to the reset values, with no done pulse.

Optional Feature:
- Macro: BACKSCATTER_GUARD_TONE_EN.
- Defined: during GUARD, rf_switch = carrier (unmodulated shifted tone), so the receiver can lock before data.
- Undefined: during GUARD, rf_switch = 0; the carrier counter still runs so MODULATE phase is identical in both builds.

Test Plan:
- Reset release with enable=0 for 20 cycles -> all outputs 0, state IDLE.
- Default parameters, enable high, data_in held 0 -> busy for (4+144)*50 = 7400 cycles.
  - rf_switch period 10 cycles during MODULATE.
  - 144 symbol_strobe pulses, bit_count=144.
  - done pulses once, then stays low until enable falls and rises again.
- Alternating data_in 1/0, changed one cycle after each symbol_strobe:
  - rf_switch phase inverts at sym_cnt==3 of each symbol.
  - Carrier edge positions otherwise unchanged (carrier phase continuous).
- enable dropped at bit_count=37, sym_cnt=20:
  - next edge: rf_switch, src_trigger, src_sending, busy all 0.
  - no done pulse.
  - re-raising enable restarts with bit_count=0.
- Reset asserted mid-MODULATE -> outputs 0 asynchronously; after release, IDLE.
- Build with BACKSCATTER_GUARD_TONE_EN: rf_switch toggles every 5 cycles during the 200 guard cycles. Without it: 0 for those 200 cycles.
